tag_sched: RTL and testbench
============================

# tag_sched

Round-robin scheduler that shares one registered tag-generation engine (32-bit word in, 8-bit tag out, one-cycle registered latency, no reset, no enable) among N requesters. Accepts one word per transaction over a valid/ready request port, drives the engine, captures the tag, and returns it with the requester ID on a valid/ready response port. Sits between the data sources and the single tag engine instance.

## Interface
- N_REQ, default 4: number of requesters, from 2 to 8.
- DATA_W, default 32: engine data width.
- TAG_W, default 8: engine tag width.
- ID_W, default $clog2(N_REQ): response ID width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*DATA_W  per-requester word; requester i occupies slice [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant/accept.
- rsp_valid  out  1  tag response valid.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_tag  out  TAG_W  captured tag.
- rsp_ready  in  1  response consumer ready.
- eng_data  out  DATA_W  word driven to the engine input.
- eng_tag  in  TAG_W  engine registered tag output.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, CAPT, RESP.
- **IDLE**
  - The round-robin arbiter picks the first asserted req_valid at or after index ptr, wrapping modulo N_REQ.
  - req_ready[g] = 1 for the winner g only. It is combinational and depends only on the current state, req_valid and ptr.
  - A handshake (req_valid[g] && req_ready[g]) latches data_q <= req_data[g] and id_q <= g, sets ptr <= (g+1) mod N_REQ, and moves to LOAD.
  - With no valid request: stay in IDLE; ptr is unchanged.
- **LOAD**: one cycle. eng_data = data_q; the engine registers tag(data_q) at the end of this cycle. Next state: CAPT.
- **CAPT**: one cycle. tag_q <= eng_tag. Next state: RESP.
- **RESP**
  - rsp_valid = 1; rsp_id = id_q; rsp_tag = tag_q. All are held stable until rsp_valid && rsp_ready.
  - On that handshake: next state is IDLE.
- eng_data = data_q in every state. data_q is held between transactions, so the engine input never glitches.
- req_ready is 0 outside IDLE. No requester is accepted while a transaction is in flight.
- Requesters must hold req_valid and req_data stable until accepted. Dropping req_valid before acceptance is legal; that request is simply not granted.

## Timing
- Latency: request handshake at the edge ending cycle T. Then LOAD is T+1, CAPT is T+2, and rsp_valid rises in T+3.
- With rsp_ready held at 1, the response handshake completes in T+3 and IDLE is T+4. Peak throughput is one word per 4 cycles.
- Reset values:
  - state = IDLE, ptr = 0.
  - data_q, id_q, tag_q = 0.
  - req_ready = 0 while rst_n is low; rsp_valid = 0, busy = 0.
  - eng_data = 0.
- Reset asserted mid-transaction aborts the transaction immediately (asynchronously). No response is produced for it. After release the bench must see IDLE with ptr = 0.
- rsp_ready held low: the FSM stalls in RESP indefinitely. Outputs stay stable and all req_ready stay 0.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by ptr. Every continuously-valid requester is served within N_REQ transactions.
- Wrap-around: after serving index N_REQ-1, ptr = 0.

## Configuration
- Macro TAG_SCHED_CHECK_EN.
- **Defined**, the block adds:
  - Input req_exp (N_REQ*TAG_W): expected tag per requester. It is latched into exp_q at request acceptance.
  - Output rsp_match (1): (tag_q == exp_q). Valid with rsp_valid; reset value 0.
  - Output mism_cnt (16): increments on each response handshake with rsp_match = 0. It saturates at 0xFFFF and resets to 0.
- **Undefined**: these ports and registers are absent, and all other behaviour is identical.

## Structure
- Shared package tag_sched_pkg holds:
  - the FSM state enum (IDLE, LOAD, CAPT, RESP);
  - DATA_W and TAG_W defaults;
  - the engine key constant 16'hDEAD, used by the bench reference model.
- Sub-module rr_arbiter (parameter N): inputs req and ptr, outputs the one-hot grant and the binary index. It is purely combinational.
- The tag engine is instantiated outside this block.

## Test plan
Engine key is 0xDEAD; N_REQ = 4 unless stated.
- **Single request**: req_valid = 0001, req_data[0] = 0x00000001, rsp_ready = 1 -> rsp_valid rises 3 cycles after accept, rsp_id = 0, rsp_tag = 0xDF.
- **Back-to-back**: requester 2 sends 0x00000100 and requester 3 sends 0x00000000, both valid at once -> responses id = 2 with tag 0xFB, then id = 3 with tag 0xFF. The second accept occurs 4 cycles after the first.
- **Fairness**: all four req_valid held high for 8 transactions -> rsp_id sequence is 0,1,2,3,0,1,2,3.
- **Backpressure**: rsp_ready = 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_tag stay stable, req_ready stays 0000, busy = 1. Raising rsp_ready completes the response and the next accept follows in IDLE.
- **Reset mid-op**: assert rst_n = 0 during CAPT -> rsp_valid = 0, busy = 0 and ptr = 0 immediately. After release, the next request from requester 0 is served first.
- **Check (TAG_SCHED_CHECK_EN)**:
  - data 0x00000001 with exp 0xDF -> rsp_match = 1.
  - data 0x00000001 with exp 0x00 -> rsp_match = 0 and mism_cnt increments to 1.

Source files
------------

// File: rtl/tag_sched_pkg.sv
// Shared definitions for the tag scheduler: FSM state encoding, default
// engine widths and the tag engine key used by reference models.
package tag_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 8;

  localparam logic [15:0] ENG_KEY = 16'hDEAD;

endpackage

// File: rtl/tag_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at
// or after ptr_i, wrapping modulo N. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W:0]   cand;

  // Scan from ptr_i upward (with wrap) and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IDX_W-1:0]] = 1'b1;
        idx_o                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tag_sched.sv
// Round-robin scheduler sharing one registered tag engine among N_REQ
// requesters. Define TAG_SCHED_CHECK_EN to add the expected-tag compare
// (req_exp input, rsp_match and mism_cnt outputs).
//
// state | meaning
// IDLE  | arbitrate; accept one request word
// LOAD  | engine registers tag(data_q) at end of cycle
// CAPT  | capture engine tag into tag_q
// RESP  | present id/tag until the consumer takes it
module tag_sched
  import tag_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       eng_data,
  input  logic [TAG_W-1:0]        eng_tag,
`ifdef TAG_SCHED_CHECK_EN
  input  logic [N_REQ*TAG_W-1:0]  req_exp,
  output logic                    rsp_match,
  output logic [15:0]             mism_cnt,
`endif
  output logic                    busy
);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   data_d;
  logic [TAG_W-1:0]    tag_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic [N_REQ-1:0]    gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                accept;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grants are only visible in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && rst_n) begin
      req_ready = gnt;
    end
  end

  // Next pointer and winning word for the acceptance in IDLE.
  always_comb begin
    accept = (state_q == IDLE) && (|gnt);
    ptr_d  = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    data_d = req_data[gnt_idx*DATA_W +: DATA_W];
  end

  // Transaction FSM with registered response and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= data_d;
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          state_q <= CAPT;
        end
        CAPT: begin
          tag_q       <= eng_tag;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_tag   = tag_q;
  assign eng_data  = data_q;
  assign busy      = busy_q;

`ifdef TAG_SCHED_CHECK_EN
  logic [TAG_W-1:0] exp_q;
  logic [15:0]      mism_cnt_q;

  // Expected tag follows the accepted word; mismatches counted on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mism_cnt_q <= '0;
    end else begin
      if (accept) begin
        exp_q <= req_exp[gnt_idx*TAG_W +: TAG_W];
      end
      if (state_q == RESP && rsp_ready && !rsp_match && mism_cnt_q != 16'hFFFF) begin
        mism_cnt_q <= mism_cnt_q + 16'd1;
      end
    end
  end

  assign rsp_match = rsp_valid_q && (tag_q == exp_q);
  assign mism_cnt  = mism_cnt_q;
`endif

endmodule

// File: tb/tb_tag_sched.sv
// Directed bench for tag_sched with N_REQ = 4 and a behavioural tag engine.
module tb_tag_sched;
  import tag_sched_pkg::*;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int TW = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;
  logic [DW-1:0] eng_data;
  logic [TW-1:0] eng_tag;
  logic          busy;
`ifdef TAG_SCHED_CHECK_EN
  logic [N*TW-1:0] req_exp;
  logic            rsp_match;
  logic [15:0]     mism_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  tag_sched #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_ready (rsp_ready),
    .eng_data  (eng_data),
    .eng_tag   (eng_tag),
`ifdef TAG_SCHED_CHECK_EN
    .req_exp   (req_exp),
    .rsp_match (rsp_match),
    .mism_cnt  (mism_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag engine: each data byte k rotated left by key nibble k (mod 8),
  // XOR-folded and inverted. Registered, no reset.
  function automatic logic [7:0] tag_fn(input logic [31:0] d);
    logic [7:0]  acc;
    logic [7:0]  b;
    logic [15:0] key;
    int          r;
    key = ENG_KEY;
    acc = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b   = d[8*k +: 8];
      r   = int'(key[4*k +: 3]);
      acc = acc ^ ((b << r) | (b >> (8 - r)));
    end
    return ~acc;
  endfunction

  always @(posedge clk) eng_tag <= tag_fn(eng_data);

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fair_id [8];
    logic [7:0]  fair_tag [4];
    fair_id  = '{0, 1, 2, 3, 0, 1, 2, 3};
    fair_tag = '{8'hDF, 8'hFB, 8'hBF, 8'hDF};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
`ifdef TAG_SCHED_CHECK_EN
    req_exp   = '0;
`endif

    // Reset state, with requests pending while reset is held
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
`ifdef TAG_SCHED_CHECK_EN
    chk("rst_match", rsp_match, 0);
    chk("rst_mism", mism_cnt, 0);
`endif
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Single request from requester 0
    req_data[0*DW +: DW] = 32'h0000_0001;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1 chk("t1_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("t1_load_busy", busy, 1);
    chk("t1_load_ready", req_ready, 0);
    chk("t1_eng_data", eng_data, 32'h1);
    chk("t1_load_valid", rsp_valid, 0);
    @(negedge clk);
    chk("t1_capt_valid", rsp_valid, 0);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_tag", rsp_tag, 8'hDF);
    @(negedge clk);
    chk("t1_idle_valid", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Back-to-back: requesters 2 and 3 both valid, ptr = 1
    req_data[2*DW +: DW] = 32'h0000_0100;
    req_data[3*DW +: DW] = 32'h0000_0000;
    req_valid = 4'b1100;
    #1 chk("t2_grant_first", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("t2_rsp1_valid", rsp_valid, 1);
    chk("t2_rsp1_id", rsp_id, 2);
    chk("t2_rsp1_tag", rsp_tag, 8'hFB);
    @(negedge clk);
    chk("t2_grant_second", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("t2_rsp2_wait");
    chk("t2_rsp2_id", rsp_id, 3);
    chk("t2_rsp2_tag", rsp_tag, 8'hFF);
    @(negedge clk);

    // Fairness: all four valid for 8 transactions, ptr = 0
    req_data[0*DW +: DW] = 32'h0000_0001;
    req_data[1*DW +: DW] = 32'h0000_0100;
    req_data[2*DW +: DW] = 32'h0001_0000;
    req_data[3*DW +: DW] = 32'h0100_0000;
    req_valid = 4'hF;
    for (int t = 0; t < 8; t++) begin
      wait_rsp("fair_wait");
      chk("fair_id", rsp_id, fair_id[t]);
      chk("fair_tag", rsp_tag, fair_tag[fair_id[t]]);
      if (t == 7) req_valid = '0;
      @(negedge clk);
    end
    chk("fair_end_busy", busy, 0);

    // Backpressure: stall in RESP for 10 cycles with other requests pending
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'hF;
    wait_rsp("bp_wait");
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_tag", rsp_tag, 8'hFB);
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0100);
    chk("bp_next_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("bp_next_wait");
    chk("bp_next_id", rsp_id, 2);
    chk("bp_next_tag", rsp_tag, 8'hBF);
    @(negedge clk);

    // Reset during CAPT; ptr = 3, so requester 1 wins first
    req_valid = 4'b0010;
    #1 chk("rm_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", req_ready, 4'b0000);
    chk("rm_eng_data", eng_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rm_ptr_zero_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("rm_wait");
    chk("rm_id", rsp_id, 0);
    chk("rm_tag", rsp_tag, 8'hDF);
    @(negedge clk);

`ifdef TAG_SCHED_CHECK_EN
    // Expected-tag compare
    req_exp[0*TW +: TW] = 8'hDF;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    wait_rsp("ck1_wait");
    chk("ck1_match", rsp_match, 1);
    @(negedge clk);
    chk("ck1_mism", mism_cnt, 0);
    req_exp[0*TW +: TW] = 8'h00;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    wait_rsp("ck2_wait");
    chk("ck2_match", rsp_match, 0);
    @(negedge clk);
    chk("ck2_mism", mism_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
